// File: rtl/bram_dp_responder.sv
// bram_dp_responder
//   True dual-port, word-addressed memory with a fixed two-cycle registered
//   read latency on each port. Port A faces the host/loader, port B faces the
//   compute engine. Both ports share one clock.
//
// Ports (x = a or b):
//   clk            single clock for both ports
//   rst            synchronous, active-high reset (memory contents survive it)
//   bram_en_x      request strobe, sampled each rising edge
//   bram_we_x      1 = write, 0 = read (ignored while bram_en_x = 0)
//   bram_addr_x    word address
//   bram_din_x     write data
//   bram_dout_x    read data; holds its value between completed reads
//   dout_valid_x   one-cycle pulse when a new read word lands on bram_dout_x
//   err_x          one-cycle pulse for an out-of-range access
//                  (the cycle after a bad write, or alongside a bad read's data)
//
// DEPTH must be at least 2 and no larger than 2**ADDR_WIDTH.

module bram_dp_responder #(
  parameter int ADDR_WIDTH = 13,
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 8192
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  bram_en_a,
  input  logic                  bram_we_a,
  input  logic [ADDR_WIDTH-1:0] bram_addr_a,
  input  logic [DATA_WIDTH-1:0] bram_din_a,
  output logic [DATA_WIDTH-1:0] bram_dout_a,
  output logic                  dout_valid_a,
  output logic                  err_a,
  input  logic                  bram_en_b,
  input  logic                  bram_we_b,
  input  logic [ADDR_WIDTH-1:0] bram_addr_b,
  input  logic [DATA_WIDTH-1:0] bram_din_b,
  output logic [DATA_WIDTH-1:0] bram_dout_b,
  output logic                  dout_valid_b,
  output logic                  err_b
);

  localparam int                  IdxW   = $clog2(DEPTH);
  localparam logic [ADDR_WIDTH:0] DepthW = (ADDR_WIDTH + 1)'(DEPTH);

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  logic            inRangeA, inRangeB;
  logic [IdxW-1:0] idxA, idxB;
  logic            wrA, wrB, rdA, rdB;

  logic [DATA_WIDTH-1:0] s1DataA_q, s1DataB_q;
  logic                  s1ValidA_q, s1ValidA_d, s1ValidB_q, s1ValidB_d;
  logic                  s1OorA_q, s1OorA_d, s1OorB_q, s1OorB_d;
  logic [DATA_WIDTH-1:0] doutA_q, doutA_d, doutB_q, doutB_d;
  logic                  validA_q, validA_d, validB_q, validB_d;
  logic                  errA_q, errA_d, errB_q, errB_d;

  // Address decode. The index is only ever used when the address is in range,
  // so the truncated slice can never alias an out-of-range request.
  assign inRangeA = {1'b0, bram_addr_a} < DepthW;
  assign inRangeB = {1'b0, bram_addr_b} < DepthW;
  assign idxA     = bram_addr_a[IdxW-1:0];
  assign idxB     = bram_addr_b[IdxW-1:0];

  // Requests seen while rst is high are discarded entirely, writes included.
  // When both ports write the same word on the same edge, port A wins and
  // port B's write is suppressed rather than racing it.
  assign wrA = bram_en_a & bram_we_a & inRangeA & ~rst;
  assign wrB = bram_en_b & bram_we_b & inRangeB & ~rst
               & ~(wrA & (bram_addr_a == bram_addr_b));
  assign rdA = bram_en_a & ~bram_we_a & ~rst;
  assign rdB = bram_en_b & ~bram_we_b & ~rst;

  always_ff @(posedge clk) begin
    if (wrA) mem[idxA] <= bram_din_a;
    if (wrB) mem[idxB] <= bram_din_b;
  end

  // Stage-1 read registers. The array read sees the contents from before this
  // edge's writes, which gives read-first behaviour across ports. No reset
  // here: the valid bit alone decides whether this word is ever used.
  always_ff @(posedge clk) begin
    if (rdA) begin
      if (inRangeA) s1DataA_q <= mem[idxA];
      else          s1DataA_q <= '0;
    end
    if (rdB) begin
      if (inRangeB) s1DataB_q <= mem[idxB];
      else          s1DataB_q <= '0;
    end
  end

  // Next-state for the pipeline control and output registers. The output bus
  // only moves when stage 1 holds a live read, so writes and idle cycles leave
  // it untouched. A bad write flags immediately; a bad read carries its flag
  // down the pipe so the error lines up with the data's valid pulse.
  always_comb begin
    s1ValidA_d = bram_en_a & ~bram_we_a;
    s1OorA_d   = ~inRangeA;
    doutA_d    = s1ValidA_q ? s1DataA_q : doutA_q;
    validA_d   = s1ValidA_q;
    errA_d     = (bram_en_a & bram_we_a & ~inRangeA) | (s1ValidA_q & s1OorA_q);

    s1ValidB_d = bram_en_b & ~bram_we_b;
    s1OorB_d   = ~inRangeB;
    doutB_d    = s1ValidB_q ? s1DataB_q : doutB_q;
    validB_d   = s1ValidB_q;
    errB_d     = (bram_en_b & bram_we_b & ~inRangeB) | (s1ValidB_q & s1OorB_q);
  end

  // Reset drops any read in flight and clears every output.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1ValidA_q <= 1'b0;
      s1OorA_q   <= 1'b0;
      doutA_q    <= '0;
      validA_q   <= 1'b0;
      errA_q     <= 1'b0;
      s1ValidB_q <= 1'b0;
      s1OorB_q   <= 1'b0;
      doutB_q    <= '0;
      validB_q   <= 1'b0;
      errB_q     <= 1'b0;
    end else begin
      s1ValidA_q <= s1ValidA_d;
      s1OorA_q   <= s1OorA_d;
      doutA_q    <= doutA_d;
      validA_q   <= validA_d;
      errA_q     <= errA_d;
      s1ValidB_q <= s1ValidB_d;
      s1OorB_q   <= s1OorB_d;
      doutB_q    <= doutB_d;
      validB_q   <= validB_d;
      errB_q     <= errB_d;
    end
  end

  assign bram_dout_a  = doutA_q;
  assign dout_valid_a = validA_q;
  assign err_a        = errA_q;
  assign bram_dout_b  = doutB_q;
  assign dout_valid_b = validB_q;
  assign err_b        = errB_q;

endmodule
